// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit scheduler: frame constants,
// opcodes, FSM encodings, frame-kind encoding and default addresses.
// No ports (package).
package arp_pkg;

  localparam int unsigned ARP_FRAME_LEN = 46;
  localparam int unsigned IP_W          = 32;

  localparam logic [15:0] ARP_OP_REQ   = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY = 16'd2;

  localparam logic [IP_W-1:0] DEFAULT_SRC_IP = {8'd192, 8'd168, 8'd10, 8'd1};

  typedef enum logic [1:0] {Q_IDLE, Q_SEND, Q_WAIT} q_state_e;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_FIRE, T_BUSY} t_state_e;

  // What the frame in flight is, so the right trigger fires and the
  // query engine hears about the end of its own request frames only.
  typedef enum logic [1:0] {K_REPLY, K_QUERY, K_GRAT} tx_kind_e;

  function automatic logic [15:0] kind_to_op(input tx_kind_e kind);
    return (kind == K_REPLY) ? ARP_OP_REPLY : ARP_OP_REQ;
  endfunction

endpackage

// File: rtl/arp_query_engine.sv
// Address-resolution query engine: accepts one query at a time, asks the
// tx FSM for request frames, times the wait for a reply after each frame
// and retries, then reports done or fail.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_query_valid/i_query_ip  query from the IP layer
//   o_query_ready             idle, query accepted on valid && ready
//   o_query_done/o_query_fail one-cycle result pulses
//   i_resolved_valid/_ip      reply seen by the receive path
//   o_send_pend_c             a request frame is wanted (combinational)
//   o_query_ip                IP being resolved
//   i_grant                   tx FSM has taken the request
//   i_req_frame_done          the granted request frame has ended
module arp_query_engine
  import arp_pkg::*;
#(
  parameter logic [31:0] P_RETRY_CYCLES = 32'd125_000_000,
  parameter logic [3:0]  P_MAX_RETRY    = 4'd3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_query_valid,
  input  logic [IP_W-1:0] i_query_ip,
  output logic            o_query_ready,
  output logic            o_query_done,
  output logic            o_query_fail,
  input  logic            i_resolved_valid,
  input  logic [IP_W-1:0] i_resolved_ip,
  output logic            o_send_pend_c,
  output logic [IP_W-1:0] o_query_ip,
  input  logic            i_grant,
  input  logic            i_req_frame_done
);

  q_state_e        state_q, state_d;
  logic [IP_W-1:0] ip_q, ip_d;
  logic [31:0]     timer_q, timer_d;
  logic [3:0]      retry_q, retry_d;
  logic            granted_q, granted_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            resolved_c;
  logic            timeout_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= Q_IDLE;
      ip_q      <= '0;
      timer_q   <= '0;
      retry_q   <= '0;
      granted_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      granted_q <= granted_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  // Next state; a matching resolution is checked before the timeout so it wins a tie.
  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    timer_d    = timer_q;
    retry_d    = retry_q;
    granted_d  = granted_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    resolved_c = i_resolved_valid && (i_resolved_ip == ip_q);
    timeout_c  = (timer_q == P_RETRY_CYCLES - 32'd1);
    case (state_q)
      Q_IDLE: begin
        if (i_query_valid && ready_q) begin
          ip_d      = i_query_ip;
          retry_d   = 4'd0;
          granted_d = 1'b0;
          state_d   = Q_SEND;
        end
      end
      Q_SEND: begin
        if (i_grant) granted_d = 1'b1;
        if (resolved_c) begin
          done_d  = 1'b1;
          state_d = Q_IDLE;
        end else if (granted_q && i_req_frame_done) begin
          timer_d = 32'd0;
          state_d = Q_WAIT;
        end
      end
      Q_WAIT: begin
        if (resolved_c) begin
          done_d  = 1'b1;
          state_d = Q_IDLE;
        end else if (timeout_c) begin
          if (retry_q < P_MAX_RETRY) begin
            retry_d   = retry_q + 4'd1;
            granted_d = 1'b0;
            state_d   = Q_SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = Q_IDLE;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = Q_IDLE;
    endcase
    ready_d = (state_d == Q_IDLE);
  end

  assign o_send_pend_c = (state_q == Q_SEND) && !granted_q;
  assign o_query_ip    = ip_q;
  assign o_query_ready = ready_q;
  assign o_query_done  = done_q;
  assign o_query_fail  = fail_q;

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP transmit scheduler: latches reply triggers, arbitrates replies,
// gratuitous announcements and query requests, loads the target IP into
// the frame transmitter, fires one trigger per frame and waits for its end.
// Optional feature macro: ARP_CTRL_GRATUITOUS_EN (gratuitous request after
// reset and on each local IP update; otherwise i_src_ip* are ignored).
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_reply_req/i_reply_ip         reply trigger from the receive path
//   i_query_valid/i_query_ip       resolution query, o_query_ready handshake
//   o_query_done/o_query_fail      query result pulses
//   i_resolved_valid/i_resolved_ip reply seen by the receive path
//   i_src_ip/i_src_ip_valid        local IP update (optional feature)
//   o_dst_ip/o_dst_ip_valid        target IP load to the transmitter
//   o_trig_reply/o_active_req      frame trigger pulses
//   i_mac_last                     transmitter end of frame
module arp_tx_ctrl
  import arp_pkg::*;
#(
  parameter logic [31:0]     P_RETRY_CYCLES = 32'd125_000_000,
  parameter logic [3:0]      P_MAX_RETRY    = 4'd3,
  parameter logic [IP_W-1:0] P_SRC_IP       = DEFAULT_SRC_IP
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_reply_req,
  input  logic [IP_W-1:0] i_reply_ip,
  input  logic            i_query_valid,
  input  logic [IP_W-1:0] i_query_ip,
  output logic            o_query_ready,
  output logic            o_query_done,
  output logic            o_query_fail,
  input  logic            i_resolved_valid,
  input  logic [IP_W-1:0] i_resolved_ip,
  input  logic [IP_W-1:0] i_src_ip,
  input  logic            i_src_ip_valid,
  output logic [IP_W-1:0] o_dst_ip,
  output logic            o_dst_ip_valid,
  output logic            o_trig_reply,
  output logic            o_active_req,
  input  logic            i_mac_last
);

  t_state_e        t_state_q, t_state_d;
  tx_kind_e        kind_q, kind_d;
  logic            reply_pend_q, reply_pend_d;
  logic [IP_W-1:0] reply_ip_q, reply_ip_d;
  logic [IP_W-1:0] dst_ip_q, dst_ip_d;
  logic            dst_ip_valid_q, dst_ip_valid_d;
  logic            trig_reply_q, trig_reply_d;
  logic            active_req_q, active_req_d;
  logic            reply_clr_c;
  logic            grat_clr_c;
  logic            grant_c;
  logic            req_frame_done_c;
  logic            send_pend_c;
  logic [IP_W-1:0] query_ip;
  logic            grat_pend;
  logic [IP_W-1:0] local_ip;

  arp_query_engine #(
    .P_RETRY_CYCLES (P_RETRY_CYCLES),
    .P_MAX_RETRY    (P_MAX_RETRY)
  ) u_query (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_query_valid    (i_query_valid),
    .i_query_ip       (i_query_ip),
    .o_query_ready    (o_query_ready),
    .o_query_done     (o_query_done),
    .o_query_fail     (o_query_fail),
    .i_resolved_valid (i_resolved_valid),
    .i_resolved_ip    (i_resolved_ip),
    .o_send_pend_c    (send_pend_c),
    .o_query_ip       (query_ip),
    .i_grant          (grant_c),
    .i_req_frame_done (req_frame_done_c)
  );

`ifdef ARP_CTRL_GRATUITOUS_EN
  logic            init_done_q;
  logic            grat_pend_q, grat_pend_d;
  logic [IP_W-1:0] src_ip_q, src_ip_d;

  // Announce once right after reset release and again on every local IP change.
  always_comb begin
    grat_pend_d = grat_pend_q;
    src_ip_d    = src_ip_q;
    if (i_src_ip_valid) src_ip_d = i_src_ip;
    if (!init_done_q || i_src_ip_valid) grat_pend_d = 1'b1;
    else if (grat_clr_c)                grat_pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_done_q <= 1'b0;
      grat_pend_q <= 1'b0;
      src_ip_q    <= P_SRC_IP;
    end else begin
      init_done_q <= 1'b1;
      grat_pend_q <= grat_pend_d;
      src_ip_q    <= src_ip_d;
    end
  end

  assign grat_pend = grat_pend_q;
  assign local_ip  = src_ip_q;
`else
  logic unused_src;
  assign unused_src = ^{i_src_ip, i_src_ip_valid, grat_clr_c};
  assign grat_pend  = 1'b0;
  assign local_ip   = P_SRC_IP;
`endif

  // Reply latch: latest IP wins, a new request beats a same-cycle clear.
  always_comb begin
    reply_pend_d = reply_pend_q;
    reply_ip_d   = reply_ip_q;
    if (i_reply_req) begin
      reply_pend_d = 1'b1;
      reply_ip_d   = i_reply_ip;
    end else if (reply_clr_c) begin
      reply_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_state_q      <= T_IDLE;
      kind_q         <= K_REPLY;
      reply_pend_q   <= 1'b0;
      reply_ip_q     <= '0;
      dst_ip_q       <= P_SRC_IP;
      dst_ip_valid_q <= 1'b0;
      trig_reply_q   <= 1'b0;
      active_req_q   <= 1'b0;
    end else begin
      t_state_q      <= t_state_d;
      kind_q         <= kind_d;
      reply_pend_q   <= reply_pend_d;
      reply_ip_q     <= reply_ip_d;
      dst_ip_q       <= dst_ip_d;
      dst_ip_valid_q <= dst_ip_valid_d;
      trig_reply_q   <= trig_reply_d;
      active_req_q   <= active_req_d;
    end
  end

  // Tx FSM; outputs are computed one state early so they register into the state that owns them.
  always_comb begin
    t_state_d        = t_state_q;
    kind_d           = kind_q;
    dst_ip_d         = dst_ip_q;
    dst_ip_valid_d   = 1'b0;
    trig_reply_d     = 1'b0;
    active_req_d     = 1'b0;
    reply_clr_c      = 1'b0;
    grat_clr_c       = 1'b0;
    grant_c          = 1'b0;
    req_frame_done_c = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (reply_pend_q) begin
          kind_d   = K_REPLY;
          dst_ip_d = reply_ip_q;
        end else if (grat_pend) begin
          kind_d   = K_GRAT;
          dst_ip_d = local_ip;
        end else if (send_pend_c) begin
          kind_d   = K_QUERY;
          dst_ip_d = query_ip;
          grant_c  = 1'b1;
        end
        if (reply_pend_q || grat_pend || send_pend_c) begin
          dst_ip_valid_d = 1'b1;
          t_state_d      = T_LOAD;
        end
      end
      T_LOAD: begin
        reply_clr_c  = (kind_q == K_REPLY);
        grat_clr_c   = (kind_q == K_GRAT);
        trig_reply_d = (kind_to_op(kind_q) == ARP_OP_REPLY);
        active_req_d = (kind_to_op(kind_q) == ARP_OP_REQ);
        t_state_d    = T_FIRE;
      end
      T_FIRE: t_state_d = T_BUSY;
      T_BUSY: begin
        if (i_mac_last) begin
          req_frame_done_c = (kind_q == K_QUERY);
          t_state_d        = T_IDLE;
        end
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  assign o_dst_ip       = dst_ip_q;
  assign o_dst_ip_valid = dst_ip_valid_q;
  assign o_trig_reply   = trig_reply_q;
  assign o_active_req   = active_req_q;

endmodule

// File: tb/tb_arp_tx_ctrl.sv
// Directed bench for arp_tx_ctrl with P_RETRY_CYCLES=100, P_MAX_RETRY=2.
// The transmitter is modelled as raising i_mac_last 46 cycles after each
// trigger. Cycle numbers: cyc advances at each rising edge; stimulus is
// driven 1ns after an edge and outputs are recorded at the falling edge,
// both tagged with the same cyc.
module tb_arp_tx_ctrl;
  import arp_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_reply_req = 1'b0;
  logic [31:0] i_reply_ip = '0;
  logic        i_query_valid = 1'b0;
  logic [31:0] i_query_ip = '0;
  logic        o_query_ready, o_query_done, o_query_fail;
  logic        i_resolved_valid = 1'b0;
  logic [31:0] i_resolved_ip = '0;
  logic [31:0] i_src_ip = '0;
  logic        i_src_ip_valid = 1'b0;
  logic [31:0] o_dst_ip;
  logic        o_dst_ip_valid, o_trig_reply, o_active_req;
  logic        i_mac_last = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef ARP_CTRL_GRATUITOUS_EN
  localparam int GRAT = 1;
`else
  localparam int GRAT = 0;
`endif

  arp_tx_ctrl #(
    .P_RETRY_CYCLES (32'd100),
    .P_MAX_RETRY    (4'd2)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_reply_req      (i_reply_req),
    .i_reply_ip       (i_reply_ip),
    .i_query_valid    (i_query_valid),
    .i_query_ip       (i_query_ip),
    .o_query_ready    (o_query_ready),
    .o_query_done     (o_query_done),
    .o_query_fail     (o_query_fail),
    .i_resolved_valid (i_resolved_valid),
    .i_resolved_ip    (i_resolved_ip),
    .i_src_ip         (i_src_ip),
    .i_src_ip_valid   (i_src_ip_valid),
    .o_dst_ip         (o_dst_ip),
    .o_dst_ip_valid   (o_dst_ip_valid),
    .o_trig_reply     (o_trig_reply),
    .o_active_req     (o_active_req),
    .i_mac_last       (i_mac_last)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Event log plus transmitter model.
  int          dv_cyc[$];
  logic [31:0] dv_ip[$];
  int          tr_cyc[$];
  int          ar_cyc[$];
  int          done_cyc[$];
  int          fail_cyc[$];
  int          both_cnt = 0;
  logic        mac_pend = 1'b0;
  int          mac_at = 0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      mac_pend   <= 1'b0;
      i_mac_last <= 1'b0;
    end else begin
      i_mac_last <= mac_pend && (cyc == mac_at);
      if (o_trig_reply || o_active_req) begin
        mac_pend <= 1'b1;
        mac_at   <= cyc + int'(ARP_FRAME_LEN);
      end else if (mac_pend && (cyc == mac_at)) begin
        mac_pend <= 1'b0;
      end
      if (o_dst_ip_valid) begin dv_cyc.push_back(cyc); dv_ip.push_back(o_dst_ip); end
      if (o_trig_reply) tr_cyc.push_back(cyc);
      if (o_active_req) ar_cyc.push_back(cyc);
      if (o_query_done) done_cyc.push_back(cyc);
      if (o_query_fail) fail_cyc.push_back(cyc);
      if (o_trig_reply && o_active_req) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    int a0, d0;
    i_rst_n = 1'b0;
    tick(3);
    checks++; if (o_query_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_query_ready); end
    checks++; if (o_dst_ip !== 32'hC0A80A01) begin failures++; $display("FAIL reset_dst_ip got=%h exp=c0a80a01", o_dst_ip); end
    checks++; if ({o_dst_ip_valid, o_trig_reply, o_active_req, o_query_done, o_query_fail} !== 5'b0)
      begin failures++; $display("FAIL reset_pulses got=%b exp=00000", {o_dst_ip_valid, o_trig_reply, o_active_req, o_query_done, o_query_fail}); end
    a0 = ar_cyc.size(); d0 = dv_cyc.size();
    i_rst_n = 1'b1;
    tick(60);
    checks++; if (ar_cyc.size() - a0 != GRAT) begin failures++; $display("FAIL post_reset_grat_count got=%0d exp=%0d", ar_cyc.size() - a0, GRAT); end
    if (GRAT == 1) begin
      checks++; if (dv_ip[d0] !== 32'hC0A80A01) begin failures++; $display("FAIL post_reset_grat_ip got=%h exp=c0a80a01", dv_ip[d0]); end
    end
  endtask

  task automatic test_reply_idle;
    int b, d0, t0, a0;
    d0 = dv_cyc.size(); t0 = tr_cyc.size(); a0 = ar_cyc.size();
    i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A07; b = cyc;
    tick(1); i_reply_req = 1'b0;
    tick(60);
    checks++; if (dv_cyc.size() - d0 != 1) begin failures++; $display("FAIL reply_dv_count got=%0d exp=1", dv_cyc.size() - d0); end
    checks++; if (dv_cyc[d0] != b + 2) begin failures++; $display("FAIL reply_dv_cycle got=%0d exp=%0d", dv_cyc[d0], b + 2); end
    checks++; if (dv_ip[d0] !== 32'hC0A80A07) begin failures++; $display("FAIL reply_dv_ip got=%h exp=c0a80a07", dv_ip[d0]); end
    checks++; if (tr_cyc.size() - t0 != 1) begin failures++; $display("FAIL reply_trig_count got=%0d exp=1", tr_cyc.size() - t0); end
    checks++; if (tr_cyc[t0] != b + 3) begin failures++; $display("FAIL reply_trig_cycle got=%0d exp=%0d", tr_cyc[t0], b + 3); end
    checks++; if (ar_cyc.size() != a0) begin failures++; $display("FAIL reply_no_active got=%0d exp=0", ar_cyc.size() - a0); end
  endtask

  // Fire times: b+3, then each frame end (fire+46) + 103 cycles.
  task automatic test_query_fail;
    int b, a0, f0, n0, d0;
    a0 = ar_cyc.size(); f0 = fail_cyc.size(); n0 = done_cyc.size(); d0 = dv_cyc.size();
    checks++; if (o_query_ready !== 1'b1) begin failures++; $display("FAIL query_ready_idle got=%0b exp=1", o_query_ready); end
    i_query_valid = 1'b1; i_query_ip = 32'hC0A80A05; b = cyc;
    tick(1); i_query_valid = 1'b0;
    checks++; if (o_query_ready !== 1'b0) begin failures++; $display("FAIL query_ready_busy got=%0b exp=0", o_query_ready); end
    tick(500);
    checks++; if (ar_cyc.size() - a0 != 3) begin failures++; $display("FAIL query_req_count got=%0d exp=3", ar_cyc.size() - a0); end
    checks++; if (ar_cyc[a0] != b + 3) begin failures++; $display("FAIL query_req1_cycle got=%0d exp=%0d", ar_cyc[a0], b + 3); end
    checks++; if (ar_cyc[a0+1] != b + 152) begin failures++; $display("FAIL query_req2_cycle got=%0d exp=%0d", ar_cyc[a0+1], b + 152); end
    checks++; if (ar_cyc[a0+2] != b + 301) begin failures++; $display("FAIL query_req3_cycle got=%0d exp=%0d", ar_cyc[a0+2], b + 301); end
    checks++; if (dv_ip[d0+2] !== 32'hC0A80A05) begin failures++; $display("FAIL query_dst_ip got=%h exp=c0a80a05", dv_ip[d0+2]); end
    checks++; if (fail_cyc.size() - f0 != 1) begin failures++; $display("FAIL query_fail_count got=%0d exp=1", fail_cyc.size() - f0); end
    checks++; if (fail_cyc[f0] != b + 448) begin failures++; $display("FAIL query_fail_cycle got=%0d exp=%0d", fail_cyc[f0], b + 448); end
    checks++; if (done_cyc.size() != n0) begin failures++; $display("FAIL query_no_done got=%0d exp=0", done_cyc.size() - n0); end
    checks++; if (o_query_ready !== 1'b1) begin failures++; $display("FAIL query_ready_back got=%0b exp=1", o_query_ready); end
  endtask

  // Q_WAIT entered at b+50; wrong IP at b+60, matching IP at b+70.
  task automatic test_resolution;
    int b, a0, f0, n0;
    a0 = ar_cyc.size(); f0 = fail_cyc.size(); n0 = done_cyc.size();
    i_query_valid = 1'b1; i_query_ip = 32'hC0A80A09; b = cyc;
    tick(1); i_query_valid = 1'b0;
    tick(59); i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A80A08;
    tick(1);  i_resolved_valid = 1'b0;
    tick(9);  i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A80A09;
    tick(1);  i_resolved_valid = 1'b0;
    tick(300);
    checks++; if (done_cyc.size() - n0 != 1) begin failures++; $display("FAIL resolve_done_count got=%0d exp=1", done_cyc.size() - n0); end
    checks++; if (done_cyc[n0] != b + 71) begin failures++; $display("FAIL resolve_done_cycle got=%0d exp=%0d", done_cyc[n0], b + 71); end
    checks++; if (ar_cyc.size() - a0 != 1) begin failures++; $display("FAIL resolve_no_retry got=%0d exp=1", ar_cyc.size() - a0); end
    checks++; if (fail_cyc.size() != f0) begin failures++; $display("FAIL resolve_no_fail got=%0d exp=0", fail_cyc.size() - f0); end
  endtask

  // Reply wins the same-cycle tie; the request is resolved while its frame is in flight.
  task automatic test_contention;
    int b, a0, d0, t0, n0;
    a0 = ar_cyc.size(); d0 = dv_cyc.size(); t0 = tr_cyc.size(); n0 = done_cyc.size();
    i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A11;
    i_query_valid = 1'b1; i_query_ip = 32'hC0A80A12; b = cyc;
    tick(1); i_reply_req = 1'b0; i_query_valid = 1'b0;
    tick(59); i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A80A12;
    tick(1);  i_resolved_valid = 1'b0;
    tick(200);
    checks++; if (dv_cyc.size() - d0 != 2) begin failures++; $display("FAIL cont_dv_count got=%0d exp=2", dv_cyc.size() - d0); end
    checks++; if (dv_ip[d0] !== 32'hC0A80A11) begin failures++; $display("FAIL cont_first_ip got=%h exp=c0a80a11", dv_ip[d0]); end
    checks++; if (tr_cyc[t0] != b + 3) begin failures++; $display("FAIL cont_reply_cycle got=%0d exp=%0d", tr_cyc[t0], b + 3); end
    checks++; if (dv_ip[d0+1] !== 32'hC0A80A12) begin failures++; $display("FAIL cont_second_ip got=%h exp=c0a80a12", dv_ip[d0+1]); end
    checks++; if (dv_cyc[d0+1] != b + 51) begin failures++; $display("FAIL cont_second_load got=%0d exp=%0d", dv_cyc[d0+1], b + 51); end
    checks++; if (ar_cyc.size() - a0 != 1) begin failures++; $display("FAIL cont_req_count got=%0d exp=1", ar_cyc.size() - a0); end
    checks++; if (ar_cyc[a0] != b + 52) begin failures++; $display("FAIL cont_req_cycle got=%0d exp=%0d", ar_cyc[a0], b + 52); end
    checks++; if (done_cyc.size() - n0 != 1) begin failures++; $display("FAIL cont_done_count got=%0d exp=1", done_cyc.size() - n0); end
  endtask

  task automatic test_back_to_back;
    int b, d0, t0, a0;
    d0 = dv_cyc.size(); t0 = tr_cyc.size(); a0 = ar_cyc.size();
    i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A21; b = cyc;
    tick(1); i_reply_req = 1'b0;
    tick(9); i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A22;
    tick(1); i_reply_req = 1'b0;
    tick(9); i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A23;
    tick(1); i_reply_req = 1'b0;
    tick(100);
    checks++; if (tr_cyc.size() - t0 != 2) begin failures++; $display("FAIL b2b_reply_count got=%0d exp=2", tr_cyc.size() - t0); end
    checks++; if (dv_ip[d0+1] !== 32'hC0A80A23) begin failures++; $display("FAIL b2b_latest_ip got=%h exp=c0a80a23", dv_ip[d0+1]); end
    checks++; if (tr_cyc[t0+1] != b + 52) begin failures++; $display("FAIL b2b_second_trig got=%0d exp=%0d", tr_cyc[t0+1], b + 52); end
    checks++; if (ar_cyc.size() != a0) begin failures++; $display("FAIL b2b_no_active got=%0d exp=0", ar_cyc.size() - a0); end
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL both_triggers got=%0d exp=0", both_cnt); end
  endtask

  // Last timeout tick (timer==99 after the 3rd frame) is cycle b+447.
  task automatic test_tie;
    int b, a0, f0, n0;
    a0 = ar_cyc.size(); f0 = fail_cyc.size(); n0 = done_cyc.size();
    i_query_valid = 1'b1; i_query_ip = 32'hC0A80A31; b = cyc;
    tick(1); i_query_valid = 1'b0;
    tick(446); i_resolved_valid = 1'b1; i_resolved_ip = 32'hC0A80A31;
    tick(1);   i_resolved_valid = 1'b0;
    tick(100);
    checks++; if (ar_cyc.size() - a0 != 3) begin failures++; $display("FAIL tie_req_count got=%0d exp=3", ar_cyc.size() - a0); end
    checks++; if (done_cyc.size() - n0 != 1) begin failures++; $display("FAIL tie_done_count got=%0d exp=1", done_cyc.size() - n0); end
    checks++; if (done_cyc[n0] != b + 448) begin failures++; $display("FAIL tie_done_cycle got=%0d exp=%0d", done_cyc[n0], b + 448); end
    checks++; if (fail_cyc.size() != f0) begin failures++; $display("FAIL tie_no_fail got=%0d exp=0", fail_cyc.size() - f0); end
  endtask

  task automatic test_reset_busy;
    int a0, t0, n0;
    i_reply_req = 1'b1; i_reply_ip = 32'hC0A80A41;
    i_query_valid = 1'b1; i_query_ip = 32'hC0A80A42;
    tick(1); i_reply_req = 1'b0; i_query_valid = 1'b0;
    tick(19);
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (o_query_ready !== 1'b1) begin failures++; $display("FAIL rst_busy_ready got=%0b exp=1", o_query_ready); end
    checks++; if (o_dst_ip !== 32'hC0A80A01) begin failures++; $display("FAIL rst_busy_dst_ip got=%h exp=c0a80a01", o_dst_ip); end
    checks++; if ({o_dst_ip_valid, o_trig_reply, o_active_req, o_query_done, o_query_fail} !== 5'b0)
      begin failures++; $display("FAIL rst_busy_pulses got=%b exp=00000", {o_dst_ip_valid, o_trig_reply, o_active_req, o_query_done, o_query_fail}); end
    tick(3);
    a0 = ar_cyc.size(); t0 = tr_cyc.size(); n0 = done_cyc.size();
    i_rst_n = 1'b1;
    tick(150);
    checks++; if (ar_cyc.size() - a0 != GRAT) begin failures++; $display("FAIL rst_busy_req_count got=%0d exp=%0d", ar_cyc.size() - a0, GRAT); end
    checks++; if (tr_cyc.size() != t0) begin failures++; $display("FAIL rst_busy_no_reply got=%0d exp=0", tr_cyc.size() - t0); end
    checks++; if (done_cyc.size() != n0) begin failures++; $display("FAIL rst_busy_no_done got=%0d exp=0", done_cyc.size() - n0); end
  endtask

  task automatic test_grat_update;
    int b, a0, d0;
    a0 = ar_cyc.size(); d0 = dv_cyc.size();
    i_src_ip = 32'hC0A80A02; i_src_ip_valid = 1'b1; b = cyc;
    tick(1); i_src_ip_valid = 1'b0;
    tick(60);
    checks++; if (ar_cyc.size() - a0 != GRAT) begin failures++; $display("FAIL grat_req_count got=%0d exp=%0d", ar_cyc.size() - a0, GRAT); end
    if (GRAT == 1) begin
      checks++; if (ar_cyc[a0] != b + 3) begin failures++; $display("FAIL grat_req_cycle got=%0d exp=%0d", ar_cyc[a0], b + 3); end
      checks++; if (dv_ip[d0] !== 32'hC0A80A02) begin failures++; $display("FAIL grat_dst_ip got=%h exp=c0a80a02", dv_ip[d0]); end
    end else begin
      checks++; if (dv_cyc.size() != d0) begin failures++; $display("FAIL grat_no_load got=%0d exp=0", dv_cyc.size() - d0); end
    end
  endtask

  initial begin
    test_reset();
    test_reply_idle();
    test_query_fail();
    test_resolution();
    test_contention();
    test_back_to_back();
    test_tie();
    test_reset_busy();
    test_grat_update();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arp_tx_ctrl.md
Name: arp_tx_ctrl

Overview:
- Scheduler sitting directly in front of the ARP frame transmitter.
- Arbitrates between two sources:
  - reply triggers from the ARP receive path;
  - address-resolution queries from the IP layer on an ARP-cache miss.
- Loads the target IP into the transmitter, fires one trigger pulse per frame and waits for frame end.
- Runs a retry/timeout engine for outstanding queries, reporting done or fail to the IP layer.

Parameters:
- P_RETRY_CYCLES, 32'd125_000_000: cycles to wait for a resolution after each request frame ends.
- P_MAX_RETRY, 4'd3: re-sends after the first request; total requests = 1 + P_MAX_RETRY.
- P_SRC_IP, {8'd192,8'd168,8'd10,8'd1}: local IP, used only by the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  async active-low reset.
- i_reply_req  in  1  one-cycle pulse: an ARP request for us was received.
- i_reply_ip  in  32  requester IP, valid with i_reply_req.
- i_query_valid  in  1  IP layer asks to resolve i_query_ip.
- i_query_ip  in  32  IP to resolve.
- o_query_ready  out  1  query engine idle; a query is accepted when valid && ready.
- o_query_done  out  1  one-cycle pulse: outstanding query resolved.
- o_query_fail  out  1  one-cycle pulse: retries exhausted.
- i_resolved_valid  in  1  pulse from the ARP receive path: reply received.
- i_resolved_ip  in  32  sender IP of that reply.
- i_src_ip  in  32  local IP update (optional feature only).
- i_src_ip_valid  in  1  local IP update strobe (optional feature only).
- o_dst_ip  out  32  target IP to the transmitter.
- o_dst_ip_valid  out  1  one-cycle load strobe.
- o_trig_reply  out  1  one-cycle pulse: transmit a reply frame.
- o_active_req  out  1  one-cycle pulse: transmit a request frame.
- i_mac_last  in  1  transmitter last-byte flag (end of frame).

Behaviour:
- Reset values: all outputs 0 except o_query_ready=1 and o_dst_ip=P_SRC_IP. Every state register, counter and pending flag is cleared asynchronously; a frame in flight is abandoned.
- Reply latch:
  - i_reply_req sets reply_pend and captures i_reply_ip.
  - A new i_reply_req while pending overwrites the IP (latest wins).
  - If set and cleared in the same cycle, set wins.
- Query engine states:
  - Q_IDLE: ready=1. On accept, capture ip, retry_cnt=0, go Q_SEND.
  - Q_SEND: wait for the tx FSM to grant. When the request frame ends, go Q_WAIT with timer=0.
  - Q_WAIT: timer increments each cycle. At timer==P_RETRY_CYCLES-1:
    - if retry_cnt<P_MAX_RETRY: retry_cnt+1, go Q_SEND;
    - else pulse o_query_fail, go Q_IDLE.
  - In Q_SEND or Q_WAIT, i_resolved_valid with i_resolved_ip==query ip pulses o_query_done and returns to Q_IDLE. This beats a same-cycle timeout.
  - Resolution during Q_SEND after the grant: the frame still completes; no retry follows.
- Tx FSM states:
  - T_IDLE: arbitrate with priority reply_pend > (gratuitous) > Q_SEND-ungranted. Go T_LOAD.
  - T_LOAD: o_dst_ip_valid=1, o_dst_ip=selected IP. Clear reply_pend if a reply was selected. Go T_FIRE.
  - T_FIRE: pulse o_trig_reply or o_active_req (never both). Go T_BUSY.
  - T_BUSY: on i_mac_last go T_IDLE and notify the query engine if the frame was a query request.
- Latency: a reply pulse in cycle N gives o_dst_ip_valid in N+2 and o_trig_reply in N+3 when idle.
- Back-to-back: the next arbitration happens in the cycle after i_mac_last; there are no dead cycles beyond T_LOAD.
- i_mac_last outside T_BUSY is ignored. There is no watchdog: the transmitter always ends a frame in a fixed 46 bytes.
- Widths: timer 32 bits, retry_cnt 4 bits. Comparisons are unsigned.

Optional Feature:
- ARP_CTRL_GRATUITOUS_EN defined:
  - After reset release, and on each i_src_ip_valid, capture the IP and set grat_pend.
  - The tx FSM then sends one request frame with o_dst_ip = local IP.
  - Priority is below reply, above query. No resolution wait.
  - The first post-reset frame uses P_SRC_IP.
- Undefined: i_src_ip and i_src_ip_valid are ignored; no unsolicited frames are sent.

Decomposition:
- Shared package arp_pkg:
  - ARP_FRAME_LEN=46;
  - ARP_OP_REQ=1 and ARP_OP_REPLY=2;
  - Q_* and T_* state encodings;
  - default IP constants.
- One sub-module, arp_query_engine: Q_* FSM, timer, retry counter, done/fail pulses. Interfaces with the tx FSM via send_pend, grant and req_frame_done.

Test Plan (P_RETRY_CYCLES=100, P_MAX_RETRY=2; i_mac_last modelled 46 cycles after the trigger):
- Reply from idle: i_reply_req with ip 192.168.10.7 at cycle 10 -> o_dst_ip_valid at 12 with C0A80A07, o_trig_reply at 13; o_active_req never pulses.
- Query, no answer: query C0A80A05 accepted -> exactly 3 o_active_req pulses spaced frame+100 cycles apart; one o_query_fail 100 cycles after the 3rd frame ends; ready returns to 1.
- Resolution: query, then i_resolved_valid with a matching IP 20 cycles into Q_WAIT -> o_query_done pulses once, no retry. A non-matching IP is ignored.
- Contention: reply and query in the same cycle -> reply frame first, request loaded the cycle after its i_mac_last. Two replies during a busy frame -> only one reply frame, carrying the latest IP.
- Tie and reset: resolve coincident with timeout -> done, not fail. i_rst_n low mid-T_BUSY -> all outputs return to reset values asynchronously, ready=1.
- With ARP_CTRL_GRATUITOUS_EN: a request frame with o_dst_ip=C0A80A01 after reset, and another after i_src_ip_valid; without the macro, none.
